// File: rtl/pal_cfg_streamer.sv
// PAL configuration port transmitter: takes stream bytes over valid/ready, shifts them out on
// cfg_clk/cfg_data and raises cfg_en when done. Optional CRC-8 of sent bits under PAL_CFG_CRC_EN.
module pal_cfg_streamer #(
  parameter int unsigned CFG_BITS = 16,
  parameter int unsigned CLK_DIV  = 2
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       cfg_clk,
  output logic       cfg_data,
  output logic       cfg_en,
  output logic       busy,
  output logic       done,
  output logic [7:0] crc
);

  localparam int unsigned CNT_W = $clog2(CFG_BITS + 1);
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_APPLIED} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]       byte_bit_q, byte_bit_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_ready_d, cfg_clk_d, cfg_data_d, cfg_en_d, busy_d, done_d;

  logic             hs, div_end, rise, bit_end, last_bit, byte_end, start_ok;
  logic [CNT_W-1:0] cnt_inc;

  assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_APPLIED));
  assign hs       = (state_q == S_LOAD) && byte_valid && byte_ready;
  assign div_end  = (div_q == DIV_LAST);
  assign rise     = (state_q == S_SHIFT) && div_end && !cfg_clk;
  assign bit_end  = (state_q == S_SHIFT) && div_end && cfg_clk;
  assign cnt_inc  = bit_cnt_q + CNT_W'(1);
  assign last_bit = (cnt_inc == CNT_LAST);
  assign byte_end = (byte_bit_q == 3'd7);

  // State register
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort wins over everything
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    if (start) state_d = S_LOAD;
        S_LOAD:    if (hs) state_d = S_SHIFT;
        S_SHIFT: begin
          if (bit_end) begin
            if (last_bit)      state_d = S_APPLIED;
            else if (byte_end) state_d = S_LOAD;
          end
        end
        S_APPLIED: if (start) state_d = S_LOAD;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Next values for every registered output and datapath register
  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    byte_bit_d   = byte_bit_q;
    div_d        = div_q;
    shift_d      = shift_q;
    byte_ready_d = byte_ready;
    cfg_clk_d    = cfg_clk;
    cfg_data_d   = cfg_data;
    cfg_en_d     = cfg_en;
    busy_d       = busy;
    done_d       = 1'b0;
    if (abort) begin
      bit_cnt_d    = '0;
      byte_bit_d   = '0;
      div_d        = '0;
      shift_d      = '0;
      byte_ready_d = 1'b0;
      cfg_clk_d    = 1'b0;
      cfg_data_d   = 1'b0;
      cfg_en_d     = 1'b0;
      busy_d       = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_APPLIED: begin
          if (start) begin
            bit_cnt_d    = '0;
            byte_bit_d   = '0;
            div_d        = '0;
            byte_ready_d = 1'b1;
            cfg_clk_d    = 1'b0;
            cfg_data_d   = 1'b0;
            cfg_en_d     = 1'b0;
            busy_d       = 1'b1;
          end
        end
        S_LOAD: begin
          if (hs) begin
            shift_d      = byte_data;
            cfg_data_d   = byte_data[0];
            byte_bit_d   = '0;
            div_d        = '0;
            byte_ready_d = 1'b0;
          end
        end
        S_SHIFT: begin
          div_d = div_end ? '0 : div_q + DIV_W'(1);
          if (rise) cfg_clk_d = 1'b1;
          // Data only moves at the falling edge, so it is stable across the whole bit
          if (bit_end) begin
            cfg_clk_d  = 1'b0;
            shift_d    = {1'b0, shift_q[7:1]};
            bit_cnt_d  = cnt_inc;
            byte_bit_d = byte_bit_q + 3'd1;
            if (last_bit) begin
              cfg_data_d = 1'b0;
              cfg_en_d   = 1'b1;
              done_d     = 1'b1;
              busy_d     = 1'b0;
            end else if (byte_end) begin
              byte_ready_d = 1'b1;
            end else begin
              cfg_data_d = shift_q[1];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      bit_cnt_q  <= '0;
      byte_bit_q <= '0;
      div_q      <= '0;
      shift_q    <= '0;
      byte_ready <= 1'b0;
      cfg_clk    <= 1'b0;
      cfg_data   <= 1'b0;
      cfg_en     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      byte_bit_q <= byte_bit_d;
      div_q      <= div_d;
      shift_q    <= shift_d;
      byte_ready <= byte_ready_d;
      cfg_clk    <= cfg_clk_d;
      cfg_data   <= cfg_data_d;
      cfg_en     <= cfg_en_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

`ifdef PAL_CFG_CRC_EN
  logic [7:0] crc_q;
  logic       crc_fb;

  assign crc_fb = crc_q[7] ^ cfg_data;

  // CRC-8 (poly 0x07) advanced on each cfg_clk rising edge with the bit being sampled
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      crc_q <= 8'h00;
    end else if (!abort) begin
      if (start_ok)  crc_q <= 8'h00;
      else if (rise) crc_q <= {crc_q[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);
    end
  end

  assign crc = crc_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
  assign crc = 8'h00;
`endif

endmodule

// File: tb/tb_pal_cfg_streamer.sv
// Directed self-checking bench for pal_cfg_streamer: three instances (16/2, 11/2, 8/1).
module tb_pal_cfg_streamer;

  logic       clk;
  logic       res_n;
  logic       start_s [3];
  logic       abort_s [3];
  logic [7:0] bd_s    [3];
  logic       bv_s    [3];
  logic       brd     [3];
  logic       cclk    [3];
  logic       cdata   [3];
  logic       cen     [3];
  logic       busy_s  [3];
  logic       done_s  [3];
  logic [7:0] crc_s   [3];

  logic [7:0] bq    [3][$];
  logic       bit_q [3][$];
  int         rc_q  [3][$];
  logic       prev  [3];
  int         dn    [3];
  int         cyc;

  int n_assert = 0;
  int n_fail   = 0;

  pal_cfg_streamer #(.CFG_BITS(16), .CLK_DIV(2)) u_a (
    .clk(clk), .res_n(res_n), .start(start_s[0]), .abort(abort_s[0]),
    .byte_data(bd_s[0]), .byte_valid(bv_s[0]), .byte_ready(brd[0]),
    .cfg_clk(cclk[0]), .cfg_data(cdata[0]), .cfg_en(cen[0]),
    .busy(busy_s[0]), .done(done_s[0]), .crc(crc_s[0]));

  pal_cfg_streamer #(.CFG_BITS(11), .CLK_DIV(2)) u_b (
    .clk(clk), .res_n(res_n), .start(start_s[1]), .abort(abort_s[1]),
    .byte_data(bd_s[1]), .byte_valid(bv_s[1]), .byte_ready(brd[1]),
    .cfg_clk(cclk[1]), .cfg_data(cdata[1]), .cfg_en(cen[1]),
    .busy(busy_s[1]), .done(done_s[1]), .crc(crc_s[1]));

  pal_cfg_streamer #(.CFG_BITS(8), .CLK_DIV(1)) u_c (
    .clk(clk), .res_n(res_n), .start(start_s[2]), .abort(abort_s[2]),
    .byte_data(bd_s[2]), .byte_valid(bv_s[2]), .byte_ready(brd[2]),
    .cfg_clk(cclk[2]), .cfg_data(cdata[2]), .cfg_en(cen[2]),
    .busy(busy_s[2]), .done(done_s[2]), .crc(crc_s[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Record every cfg_clk rise (with its data bit and cycle) and every done pulse
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (cclk[i] && !prev[i]) begin
        bit_q[i].push_back(cdata[i]);
        rc_q[i].push_back(cyc);
      end
      prev[i] <= cclk[i];
      if (done_s[i]) dn[i] <= dn[i] + 1;
    end
  end

  // Byte feeders: present the head of each queue, pop it on a handshake
  for (genvar g = 0; g < 3; g++) begin : g_feed
    initial begin
      bv_s[g] = 1'b0;
      bd_s[g] = 8'h00;
      forever begin
        @(posedge clk);
        if (bv_s[g] && brd[g] && bq[g].size() > 0) void'(bq[g].pop_front());
        #1;
        if (bq[g].size() > 0) begin
          bv_s[g] = 1'b1;
          bd_s[g] = bq[g][0];
        end else begin
          bv_s[g] = 1'b0;
          bd_s[g] = 8'h00;
        end
      end
    end
  end

  function automatic logic [7:0] crc_model(input logic [15:0] v, input int n);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int k = 0; k < n; k++) begin
      fb = c[7] ^ v[k];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_pulse(input int i);
    @(posedge clk); #1 start_s[i] = 1'b1;
    @(posedge clk); #1 start_s[i] = 1'b0;
  endtask

  task automatic wait_en(input int i, input int lim, input string tag);
    int n = 0;
    while (cen[i] !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(cen[i]), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_rises(input int i, input int base, input int k, input string tag);
    int n = 0;
    while (rc_q[i].size() < base + k && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(rc_q[i].size() >= base + k), 32'd1);
  endtask

  task automatic check_stream(input int i, input int base, input int nbits,
                              input logic [15:0] exp, input int gap, input string tag);
    logic [15:0] got;
    int          bad;
    int          have;
    got  = '0;
    bad  = 0;
    have = rc_q[i].size() - base;
    chk({tag, "_rises"}, 32'(have), 32'(nbits));
    for (int j = 0; j < nbits && j < have; j++) got[j] = bit_q[i][base + j];
    chk({tag, "_bits"}, 32'(got), 32'(exp));
    for (int j = 1; j < nbits && j < have; j++)
      if ((j % 8) != 0 && (rc_q[i][base + j] - rc_q[i][base + j - 1]) != gap) bad++;
    chk({tag, "_gap"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int base;
    int dbase;
    int bad;
    int n;
    logic [7:0] exp_crc16;
    cyc   = 0;
    res_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0;
      abort_s[i] = 1'b0;
      prev[i]    = 1'b0;
      dn[i]      = 0;
    end
`ifdef PAL_CFG_CRC_EN
    exp_crc16 = crc_model(16'h3CA5, 16);
`else
    exp_crc16 = 8'h00;
`endif

    // Reset values
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk($sformatf("reset_outs%0d", i),
          32'({brd[i], cclk[i], cdata[i], cen[i], busy_s[i], done_s[i], crc_s[i]}), 32'd0);
    @(posedge clk); #1 res_n = 1'b1;

    // Basic 16-bit stream
    base  = rc_q[0].size();
    dbase = dn[0];
    bq[0].push_back(8'hA5);
    bq[0].push_back(8'h3C);
    start_pulse(0);
    chk("basic_busy", 32'(busy_s[0]), 32'd1);
    wait_en(0, 300, "basic_en");
    check_stream(0, base, 16, 16'h3CA5, 4, "basic");
    chk("basic_done_once", 32'(dn[0] - dbase), 32'd1);
    chk("basic_idle_outs", 32'({busy_s[0], cclk[0], cdata[0], brd[0]}), 32'd0);
    chk("basic_crc", 32'(crc_s[0]), 32'(exp_crc16));

    // Reconfigure from APPLIED, ignore start in SHIFT, stall on second byte
    base  = rc_q[0].size();
    dbase = dn[0];
    bq[0].push_back(8'hA5);
    start_pulse(0);
    chk("reconf_en_drop", 32'({cen[0], brd[0]}), 32'b01);
    wait_rises(0, base, 3, "shift_rises3");
    start_pulse(0);
    wait_rises(0, base, 8, "stall_rises8");
    n = 0;
    while (brd[0] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("stall_ready", 32'(brd[0]), 32'd1);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cclk[0] !== 1'b0 || brd[0] !== 1'b1) bad++;
    end
    chk("stall_hold", 32'(bad), 32'd0);
    bq[0].push_back(8'h3C);
    wait_en(0, 300, "stall_en");
    check_stream(0, base, 16, 16'h3CA5, 4, "stall");
    chk("stall_done_once", 32'(dn[0] - dbase), 32'd1);

    // Partial final byte on the 11-bit instance
    base  = rc_q[1].size();
    dbase = dn[1];
    bq[1].push_back(8'hFF);
    bq[1].push_back(8'h05);
    start_pulse(1);
    wait_en(1, 300, "partial_en");
    check_stream(1, base, 11, 16'h05FF, 4, "partial");
    chk("partial_done_once", 32'(dn[1] - dbase), 32'd1);

    // Abort mid-shift, then a fresh full stream
    base = rc_q[0].size();
    bq[0].push_back(8'hA5);
    bq[0].push_back(8'h3C);
    start_pulse(0);
    wait_rises(0, base, 5, "abort_rises5");
    bq[0].delete();
    @(posedge clk); #1 abort_s[0] = 1'b1;
    @(posedge clk); #1 abort_s[0] = 1'b0;
    chk("abort_outs", 32'({cclk[0], cdata[0], cen[0], busy_s[0], brd[0]}), 32'd0);
    n = rc_q[0].size();
    repeat (30) @(negedge clk);
    chk("abort_no_edges", 32'(rc_q[0].size() - n), 32'd0);
    base = rc_q[0].size();
    bq[0].push_back(8'hA5);
    bq[0].push_back(8'h3C);
    start_pulse(0);
    wait_en(0, 300, "restart_en");
    check_stream(0, base, 16, 16'h3CA5, 4, "restart");

    // CLK_DIV=1, single byte, CRC of bits 0,0,0,0,0,0,0,1
    base = rc_q[2].size();
    bq[2].push_back(8'h80);
    start_pulse(2);
    wait_en(2, 100, "div1_en");
    check_stream(2, base, 8, 16'h0080, 2, "div1");
`ifdef PAL_CFG_CRC_EN
    chk("div1_crc", 32'(crc_s[2]), 32'h07);
`else
    chk("div1_crc", 32'(crc_s[2]), 32'h00);
`endif

    // Asynchronous reset in the middle of a stream
    base = rc_q[1].size();
    bq[1].push_back(8'hFF);
    bq[1].push_back(8'h05);
    start_pulse(1);
    wait_rises(1, base, 3, "arst_rises3");
    @(posedge clk); #2 res_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("arst_outs%0d", i),
          32'({brd[i], cclk[i], cdata[i], cen[i], busy_s[i], done_s[i], crc_s[i]}), 32'd0);
    bq[1].delete();
    @(posedge clk); #1 res_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
